// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches one aligned block from pipelined main memory, streams each
// returned word into the data array and pulses the tag write when the last word lands.
module cache_fill_fsm #(
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [15:0]       memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              memory_enable,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic [15:0]       fill_data,
    output logic [ADDR_W-1:0] block_address
);

    localparam int unsigned CW  = $clog2(BLOCK_WORDS);
    localparam int unsigned OFS = CW + 1;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e            state_q, state_d;
    // MSB of each counter is its done flag; it sets after BLOCK_WORDS increments.
    logic [CW:0]       req_cnt_q, req_cnt_d;
    logic [CW:0]       rsp_cnt_q, rsp_cnt_d;
    logic [ADDR_W-1:0] block_q, block_d;

    always_comb begin
        state_d          = state_q;
        req_cnt_d        = req_cnt_q;
        rsp_cnt_d        = rsp_cnt_q;
        block_d          = block_q;
        fsm_busy         = 1'b0;
        memory_enable    = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_address     = '0;

        unique case (state_q)
            StIdle: begin
                if (miss_detected) begin
                    state_d   = StFill;
                    block_d   = {miss_address[ADDR_W-1:OFS], {OFS{1'b0}}};
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                end
            end
            StFill: begin
                fsm_busy = 1'b1;
                if (!req_cnt_q[CW]) begin
                    memory_enable  = 1'b1;
                    // Base is aligned, so base + 2*cnt is a plain concatenation (never carries).
                    memory_address = {block_q[ADDR_W-1:OFS], req_cnt_q[CW-1:0], 1'b0};
                    req_cnt_d      = req_cnt_q + 1'b1;
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_address     = {block_q[ADDR_W-1:OFS], rsp_cnt_q[CW-1:0], 1'b0};
                    rsp_cnt_d        = rsp_cnt_q + 1'b1;
                    if (rsp_cnt_q == (CW + 1)'(BLOCK_WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        state_d         = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign fill_data     = memory_data;
    assign block_address = block_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            block_q   <= '0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            block_q   <= block_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: directed scenarios plus random fills, with an in-order pipelined
// memory model and expected per-cycle outputs derived from the fill timeline arithmetic.
module tb_cache_fill_fsm;

    localparam int unsigned BW = 8;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic [15:0]   memory_data;
    logic          memory_data_valid;
    logic          fsm_busy;
    logic          memory_enable;
    logic [AW-1:0] memory_address;
    logic          write_data_array;
    logic          write_tag_array;
    logic [AW-1:0] fill_address;
    logic [15:0]   fill_data;
    logic [AW-1:0] block_address;

    int            tests = 0;
    int            fails = 0;
    logic [AW-1:0] exp_block;

    always #5 clk = ~clk;

    cache_fill_fsm #(
        .BLOCK_WORDS(BW),
        .ADDR_W     (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data      (memory_data),
        .memory_data_valid(memory_data_valid),
        .fsm_busy         (fsm_busy),
        .memory_enable    (memory_enable),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .fill_address     (fill_address),
        .fill_data        (fill_data),
        .block_address    (block_address)
    );

    // Content of main memory at a byte address.
    function automatic logic [15:0] mdata(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One idle cycle with a spurious memory return; nothing may be written.
    task automatic idle_cycle();
        miss_detected     = 1'b0;
        memory_data_valid = 1'b1;
        memory_data       = 16'($urandom);
        #1;
        chk("idle_busy", fsm_busy, 0);
        chk("idle_en", memory_enable, 0);
        chk("idle_maddr", memory_address, 0);
        chk("idle_wr", write_data_array, 0);
        chk("idle_tag", write_tag_array, 0);
        chk("idle_faddr", fill_address, 0);
        chk("idle_block", block_address, exp_block);
        @(negedge clk);
        memory_data_valid = 1'b0;
    endtask

    // Cycle 0 raises the miss; cycles 1..BW+lat are the fill. rst_at != 0 resets at that cycle.
    task automatic run_fill(input logic [15:0] maddr, input int lat, input bit hold,
                            input int rst_at);
        logic [15:0] b;
        logic [15:0] qa[$];
        int          qt[$];
        int          nwr;
        int          ntag;
        bit          dead;
        bit          e_en;
        bit          e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_fa;
        b    = {maddr[15:4], 4'h0};
        nwr  = 0;
        ntag = 0;
        miss_detected     = 1'b1;
        miss_address      = maddr;
        memory_data_valid = 1'b0;
        #1;
        chk("c0_busy", fsm_busy, 0);
        chk("c0_block", block_address, exp_block);
        @(negedge clk);
        for (int c = 1; c <= int'(BW) + lat; c++) begin
            if (!hold) miss_detected = 1'b0;
            miss_address = 16'($urandom);
            rst  = (rst_at != 0 && c == rst_at);
            dead = (rst_at != 0 && c >= rst_at);
            if (qt.size() > 0 && qt[0] == c) begin
                memory_data_valid = 1'b1;
                memory_data       = mdata(qa[0]);
                void'(qa.pop_front());
                void'(qt.pop_front());
            end else begin
                memory_data_valid = 1'b0;
                memory_data       = 16'($urandom);
            end
            #1;
            e_en   = !dead && c <= int'(BW);
            e_addr = e_en ? b + 16'(2 * (c - 1)) : 16'h0;
            e_wr   = !dead && c > lat;
            e_fa   = e_wr ? b + 16'(2 * (c - lat - 1)) : 16'h0;
            chk("busy", fsm_busy, !dead);
            chk("mem_en", memory_enable, e_en);
            chk("mem_addr", memory_address, e_addr);
            chk("wr_data", write_data_array, e_wr);
            chk("fill_addr", fill_address, e_fa);
            chk("wr_tag", write_tag_array, !dead && c == int'(BW) + lat);
            chk("block", block_address, dead ? 16'h0 : b);
            if (e_wr) chk("fill_data", fill_data, mdata(e_fa));
            nwr  += int'(write_data_array);
            ntag += int'(write_tag_array);
            if (memory_enable === 1'b1) begin
                qa.push_back(memory_address);
                qt.push_back(c + lat);
            end
            @(negedge clk);
        end
        rst       = 1'b0;
        exp_block = (rst_at != 0) ? 16'h0 : b;
        if (rst_at == 0) begin
            chk("n_writes", nwr, BW);
            chk("n_tags", ntag, 1);
        end
    endtask

    initial begin
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = '0;
        memory_data       = '0;
        memory_data_valid = 1'b0;
        exp_block         = '0;
        @(negedge clk);
        #1;
        chk("rst_busy", fsm_busy, 0);
        chk("rst_en", memory_enable, 0);
        chk("rst_wr", write_data_array, 0);
        chk("rst_tag", write_tag_array, 0);
        chk("rst_block", block_address, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        run_fill(16'h1236, 4, 1'b0, 0);
        idle_cycle();
        run_fill(16'hFFF8, 3, 1'b0, 0);
        idle_cycle();

        idle_cycle();
        run_fill(16'h0A5E, 2, 1'b1, 0);
        idle_cycle();

        run_fill(16'h7770, 4, 1'b0, 6);
        idle_cycle();
        run_fill(16'h0040, 5, 1'b0, 0);
        idle_cycle();

        run_fill(16'h0100, 3, 1'b0, 0);
        run_fill(16'h0200, 3, 1'b0, 0);
        idle_cycle();

        for (int k = 0; k < 20; k++) begin
            run_fill(16'($urandom), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
